// File: rtl/xbtn_debounce_pkg.sv
// ============================================================================
// Module : xbtn_debounce_pkg
// Brief  : Shared bus addresses, data width and FSM state encoding for the
//          push-button conditioner.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xbtn_debounce_pkg;

  localparam int XDEF_DATA_W = 32;

  localparam logic BTN_STATUS_ADDR = 1'b0;
  localparam logic BTN_COUNT_ADDR  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

endpackage

`default_nettype wire

// File: rtl/xbtn_debounce_if.sv
// ============================================================================
// Module : xbtn_debounce_if
// Brief  : Pin, register-bus and status signals of the push-button block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xbtn_debounce_if #(
  parameter int DATA_W = 32
) ();
  logic              push_btn;
  logic              sel;
  logic              we;
  logic              addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              button;
  logic              press;

  modport master (
    output push_btn, sel, we, addr, data_in,
    input  data_out, button, press
  );

  modport slave (
    input  push_btn, sel, we, addr, data_in,
    output data_out, button, press
  );
endinterface

`default_nettype wire

// File: rtl/xbtn_sync.sv
// ============================================================================
// Module : xbtn_sync
// Brief  : Two-flop synchroniser for an asynchronous input pin.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xbtn_sync (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_d,
  output logic      o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

`default_nettype wire

// File: rtl/xbtn_debounce.sv
// ============================================================================
// Module : xbtn_debounce
// Brief  : Synchronises and debounces the push-button pin, keeps a sticky
//          press-pending flag and exposes STATUS/COUNT registers.
//          Optional press counter enabled by macro BTN_PRESS_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xbtn_debounce
  import xbtn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 16,
  parameter int DATA_W          = XDEF_DATA_W
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  xbtn_debounce_if.slave  bus
);

  localparam int            C_DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [C_DW-1:0] C_CNT_LAST = C_DW'(DEBOUNCE_CYCLES - 2);

  logic             w_sync;
  btn_state_e       r_state;
  logic [C_DW-1:0]  r_cnt;
  logic             r_button;
  logic             r_press;
  logic             r_pending;
  logic             w_wr;
  logic             w_st_clr;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_count_rd;
  logic [DATA_W-1:0] w_rdata;
  logic             w_unused;

  xbtn_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.push_btn),
    .o_q   (w_sync)
  );

  // The counter stops at C_CNT_LAST because that value always leaves the wait state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_button <= 1'b0;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sync) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_sync) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_CNT_LAST) begin
            r_state  <= ST_PRESSED;
            r_button <= 1'b1;
            r_press  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!w_sync) begin
            r_state <= ST_RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (w_sync) begin
            r_state <= ST_PRESSED;
          end else if (r_cnt == C_CNT_LAST) begin
            r_state  <= ST_IDLE;
            r_button <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_cnt    <= '0;
          r_button <= 1'b0;
        end
      endcase
    end
  end

  assign w_wr     = bus.sel & bus.we;
  assign w_st_clr = w_wr & (bus.addr == BTN_STATUS_ADDR) & bus.data_in[1];

  // A press arriving with a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (r_press) begin
      r_pending <= 1'b1;
    end else if (w_st_clr) begin
      r_pending <= 1'b0;
    end
  end

`ifdef BTN_PRESS_CNT_EN
  logic [CNT_W-1:0] r_count;
  logic             w_cnt_clr;

  assign w_cnt_clr = w_wr & (bus.addr == BTN_COUNT_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_cnt_clr) begin
      r_count <= r_press ? CNT_W'(1) : '0;
    end else if (r_press) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign w_count_rd = DATA_W'(r_count);
  assign w_unused   = ^{bus.data_in[DATA_W-1:2], bus.data_in[0]};
`else
  assign w_count_rd = '0;
  assign w_unused   = (^{bus.data_in[DATA_W-1:2], bus.data_in[0]}) ^ (CNT_W > 0);
`endif

  assign w_status = {{(DATA_W-2){1'b0}}, r_pending, r_button};

  always_comb begin
    w_rdata = '0;
    if (bus.sel) begin
      w_rdata = (bus.addr == BTN_COUNT_ADDR) ? w_count_rd : w_status;
    end
  end

  assign bus.data_out = w_rdata;
  assign bus.button   = r_button;
  assign bus.press    = r_press;

endmodule

`default_nettype wire

// File: tb/tb_xbtn_debounce.sv
// ============================================================================
// Module : tb_xbtn_debounce
// Brief  : Randomised and directed scoreboard bench for xbtn_debounce.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xbtn_debounce;

  localparam int D      = 4;
  localparam int CNT_W  = 4;
  localparam int DATA_W = 32;

`ifdef BTN_PRESS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    bit button;
    bit press;
    bit pending;
    int count;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  xbtn_debounce_if #(.DATA_W(DATA_W)) bus ();

  xbtn_debounce #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CNT_W),
    .DATA_W          (DATA_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: level accepted after D consecutive agreeing samples of
  // the pin seen two clocks late.
  exp_t sbq[$];
  bit   m_s1, m_s2, m_button, m_press, m_pending;
  int   m_count;
  bit   hist[$];

  initial begin
    m_s1 = 0; m_s2 = 0; m_button = 0; m_press = 0; m_pending = 0; m_count = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_s1 = 0; m_s2 = 0; m_button = 0; m_press = 0; m_pending = 0; m_count = 0;
        hist.delete();
      end else begin
        bit smp, all1, all0, nb, np, wr;
        int nc;
        smp  = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.push_btn;
        hist.push_back(smp);
        if (hist.size() > D) void'(hist.pop_front());
        all1 = (hist.size() == D);
        all0 = (hist.size() == D);
        foreach (hist[i]) begin
          if (!hist[i]) all1 = 0;
          if (hist[i])  all0 = 0;
        end
        nb = m_button ? !all0 : all1;
        wr = bus.sel && bus.we;
        np = m_pending;
        if (wr && bus.addr == 1'b0 && bus.data_in[1]) np = 0;
        if (m_press) np = 1;
        nc = m_count;
        if (CNT_EN) begin
          if (wr && bus.addr == 1'b1) nc = 0;
          if (m_press) nc = (nc + 1) % (1 << CNT_W);
        end
        m_press   = !m_button && nb;
        m_button  = nb;
        m_pending = np;
        m_count   = nc;
      end
      sbq.push_back('{m_button, m_press, m_pending, m_count});
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per clock, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        exp_t e;
        longint ed;
        e = sbq.pop_front();
        chk("button", bus.button, e.button);
        chk("press", bus.press, e.press);
        if (!bus.sel)            ed = 0;
        else if (bus.addr)       ed = e.count;
        else                     ed = {e.pending, e.button};
        chk(bus.addr ? "data_out_count" : "data_out_status", bus.data_out, ed);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    bus.sel = 0; bus.we = 0; bus.addr = 0; bus.data_in = '0;
  endtask

  task automatic rd(input bit a);
    bus.sel = 1; bus.we = 0; bus.addr = a; bus.data_in = '0;
  endtask

  task automatic wait_model_press();
    int n;
    n = 0;
    while (!m_press && n < 40) begin
      cyc(1);
      n++;
    end
    if (!m_press) chk("press_timeout", 0, 1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 0;
    bus.push_btn = 1;
    bus_idle();
    rd(0);

    // Reset with pin high, then release and hold.
    cyc(4);
    rst_n = 1;
    cyc(10);

    // Bounce that never settles long enough.
    bus.push_btn = 0; cyc(10);
    rd(0); bus.data_in = 32'h2; bus.we = 1; cyc(1); rd(0);
    bus.push_btn = 1; cyc(2); bus.push_btn = 0; cyc(1);
    bus.push_btn = 1; cyc(2); bus.push_btn = 0; cyc(10);

    // Stable press, W1C, release.
    bus.push_btn = 1; cyc(10);
    bus.we = 1; bus.data_in = 32'h2; cyc(1); rd(0); cyc(2);
    bus.we = 1; bus.data_in = 32'h1; cyc(1); rd(0); cyc(1);
    bus.push_btn = 0; cyc(10);

    // Clear writes coinciding with the press pulse.
    bus.push_btn = 1;
    wait_model_press();
    bus.sel = 1; bus.we = 1; bus.addr = 0; bus.data_in = 32'h2; cyc(1); rd(0); cyc(3);
    bus.push_btn = 0; cyc(10);
    bus.push_btn = 1;
    wait_model_press();
    bus.sel = 1; bus.we = 1; bus.addr = 1; bus.data_in = 32'h0; cyc(1); rd(1); cyc(3);
    bus.push_btn = 0; cyc(10);

    // Clear count, then 17 clean presses to wrap the 4-bit counter.
    bus.sel = 1; bus.we = 1; bus.addr = 1; cyc(1); rd(1);
    for (int i = 0; i < 17; i++) begin
      bus.push_btn = 1; cyc(8);
      bus.push_btn = 0; cyc(8);
    end
    bus.sel = 1; bus.we = 1; bus.addr = 1; bus.data_in = 32'hFFFF_FFFF; cyc(1); rd(1); cyc(2);

    // Asynchronous reset in the middle of a press debounce.
    rd(1);
    bus.push_btn = 1;
    @(negedge clk);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 0;
    bus.push_btn = 0;
    #1;
    chk("async_rst_button", bus.button, 0);
    chk("async_rst_press", bus.press, 0);
    chk("async_rst_count", bus.data_out, 0);
    cyc(2);
    rst_n = 1;
    rd(0);
    cyc(12);

    // Randomised pin activity and register traffic.
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      bus.push_btn = $urandom_range(0, 1);
      len = $urandom_range(1, D + 4);
      for (int k = 0; k < len; k++) begin
        bus.sel     = $urandom_range(0, 3) != 0;
        bus.we      = $urandom_range(0, 5) == 0;
        bus.addr    = $urandom_range(0, 1);
        bus.data_in = $urandom;
        cyc(1);
      end
    end
    bus_idle();
    bus.push_btn = 0;
    cyc(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
